// File: rtl/byte_computer_run_ctrl_if.sv
// Pin-side and core-side signals of the byte computer run controller.
// master = the controller, slave = the pins/core around it.
interface byte_computer_run_ctrl_if #(
    parameter int AW = 5
);
    logic [1:0]    cmd;
    logic          strobe;
    logic [7:0]    data_in;
    logic          cpu_halt;
    logic          cpu_start;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          busy;
    logic [2:0]    state_o;

    modport master (
        input  cmd, strobe, data_in, cpu_halt,
        output cpu_start, mem_we, mem_addr, mem_wdata, busy, state_o
    );

    modport slave (
        output cmd, strobe, data_in, cpu_halt,
        input  cpu_start, mem_we, mem_addr, mem_wdata, busy, state_o
    );
endinterface

// File: rtl/byte_computer_run_ctrl.sv
// Load / run / dump sequencer for the byte computer.
// Define RUN_TIMEOUT_EN to add the RUN watchdog and ERROR state.
module byte_computer_run_ctrl #(
    parameter int AW        = 5,
    parameter int TIMEOUT_W = 16
) (
    input logic clk,
    input logic rst,
    byte_computer_run_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_HALTED = 3'd3,
        S_DUMP   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    localparam logic [AW-1:0] ADDR_LAST = '1;

    state_t        state;
    logic          s1, s2, s3;
    logic          ev;
    logic          cpu_start;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;

`ifdef RUN_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] WD_LAST = '1;
    logic [TIMEOUT_W-1:0] wd;
`else
    localparam int unused_timeout_w = TIMEOUT_W;
`endif

    assign ev = s2 & ~s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            cpu_start <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
`ifdef RUN_TIMEOUT_EN
            wd        <= '0;
`endif
        end else begin
            s1     <= bus.strobe;
            s2     <= s1;
            s3     <= s2;
            mem_we <= 1'b0;
            unique case (state)
                S_IDLE, S_HALTED: begin
                    if (ev) begin
                        case (bus.cmd)
                            2'b01: begin
                                state    <= S_LOAD;
                                mem_addr <= '0;
                            end
                            2'b10: begin
                                state <= S_RUN;
`ifdef RUN_TIMEOUT_EN
                                wd    <= '0;
`endif
                            end
                            2'b11: begin
                                state    <= S_DUMP;
                                mem_addr <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                // The address advances the cycle after the write pulse.
                S_LOAD: begin
                    if (mem_we) begin
                        mem_addr <= mem_addr + 1'b1;
                        if (mem_addr == ADDR_LAST)
                            state <= S_IDLE;
                    end else if (ev) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= bus.data_in;
                    end
                end
                S_RUN: begin
`ifdef RUN_TIMEOUT_EN
                    wd <= wd + 1'b1;
`endif
                    if (!cpu_start) begin
                        cpu_start <= 1'b1;
                    end else if (bus.cpu_halt) begin
                        cpu_start <= 1'b0;
                        state     <= S_HALTED;
`ifdef RUN_TIMEOUT_EN
                    end else if (wd == WD_LAST) begin
                        cpu_start <= 1'b0;
                        state     <= S_ERROR;
`endif
                    end
                end
                S_DUMP: begin
                    if (ev) begin
                        if (mem_addr == ADDR_LAST) begin
                            mem_addr <= '0;
                            state    <= S_HALTED;
                        end else begin
                            mem_addr <= mem_addr + 1'b1;
                        end
                    end
                end
                S_ERROR: begin
                    if (ev && bus.cmd == 2'b01) begin
                        state    <= S_LOAD;
                        mem_addr <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.cpu_start = cpu_start;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.state_o   = state;
    assign bus.busy      = (state == S_LOAD) || (state == S_RUN) ||
                           (state == S_DUMP);
endmodule

// File: tb/tb_byte_computer_run_ctrl.sv
// Directed self-checking bench for byte_computer_run_ctrl.
// Watchdog scenario is exercised when RUN_TIMEOUT_EN is defined.
module tb_byte_computer_run_ctrl;
    localparam int AW = 5;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    byte_computer_run_ctrl_if #(.AW(AW)) bus ();

    byte_computer_run_ctrl #(.AW(AW), .TIMEOUT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int       we_cnt = 0;
    int       start_cnt = 0;
    int       viol = 0;
    logic     we_prev = 1'b0;
    logic [AW-1:0] log_addr [64];
    logic [7:0]    log_data [64];

    always @(negedge clk) begin
        if (bus.mem_we) begin
            if (we_cnt < 64) begin
                log_addr[we_cnt] = bus.mem_addr;
                log_data[we_cnt] = bus.mem_wdata;
            end
            we_cnt++;
            if (we_prev) viol++;
            if (bus.state_o !== 3'd1) viol++;
        end
        if (bus.mem_we && bus.cpu_start) viol++;
        if (bus.cpu_start) start_cnt++;
        we_prev = bus.mem_we;
    end

    task automatic strobe_pulse(input int hold);
        @(negedge clk) bus.strobe = 1'b1;
        repeat (hold) @(negedge clk);
        bus.strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.cmd = 2'b01;
        bus.data_in = 8'h3C;
        bus.cpu_halt = 1'b0;
        bus.strobe = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.state_o, bus.cpu_start, bus.mem_we, bus.busy} !== 6'd0 ||
            bus.mem_addr !== '0 || bus.mem_wdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs state=%0d start=%b we=%b busy=%b addr=%0d wdata=%h required all 0",
                     bus.state_o, bus.cpu_start, bus.mem_we, bus.busy,
                     bus.mem_addr, bus.mem_wdata);
        end
        for (int i = 0; i < 3; i++) strobe_pulse(3);
        checks++;
        if (we_cnt !== 0 || bus.state_o !== 3'd0) begin
            failures++;
            $display("FAIL reset_hold writes=%0d state=%0d required 0/0",
                     we_cnt, bus.state_o);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_nop();
        bus.cmd = 2'b00;
        strobe_pulse(2);
        checks++;
        if (bus.state_o !== 3'd0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL nop_cmd state=%0d busy=%b required 0/0",
                     bus.state_o, bus.busy);
        end
    endtask

    task automatic test_load();
        int bad;
        bus.cmd = 2'b01;
        strobe_pulse(2);
        checks++;
        if (bus.state_o !== 3'd1 || bus.busy !== 1'b1 || bus.mem_addr !== '0) begin
            failures++;
            $display("FAIL load_entry state=%0d busy=%b addr=%0d required 1/1/0",
                     bus.state_o, bus.busy, bus.mem_addr);
        end
        bus.cmd = 2'b11;
        for (int i = 0; i < DEPTH; i++) begin
            bus.data_in = 8'(i) ^ 8'hA5;
            strobe_pulse(2);
        end
        @(negedge clk);
        checks++;
        if (we_cnt !== DEPTH) begin
            failures++;
            $display("FAIL load_count writes=%0d required %0d", we_cnt, DEPTH);
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (log_addr[i] !== AW'(i) || log_data[i] !== (8'(i) ^ 8'hA5)) begin
                failures++;
                bad++;
                $display("FAIL load_write[%0d] addr=%0d data=%h required %0d/%h",
                         i, log_addr[i], log_data[i], i, 8'(i) ^ 8'hA5);
            end
        end
        checks++;
        if (bus.state_o !== 3'd0 || bus.mem_addr !== '0) begin
            failures++;
            $display("FAIL load_done state=%0d addr=%0d required 0/0",
                     bus.state_o, bus.mem_addr);
        end
    endtask

    task automatic test_run();
        int n;
        bit seen;
        bus.cmd = 2'b10;
        bus.cpu_halt = 1'b0;
        start_cnt = 0;
        seen = 0;
        @(negedge clk) bus.strobe = 1'b1;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.cpu_start) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen || bus.state_o !== 3'd2 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL run_entry start_seen=%0d state=%0d required 1/2",
                     seen, bus.state_o);
        end
        repeat (9) @(negedge clk);
        bus.cpu_halt = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cpu_start !== 1'b0 || bus.state_o !== 3'd3) begin
            failures++;
            $display("FAIL run_halt start=%b state=%0d required 0/3",
                     bus.cpu_start, bus.state_o);
        end
        bus.strobe = 1'b0;
        bus.cpu_halt = 1'b0;
        @(negedge clk);
        checks++;
        if (start_cnt !== 10) begin
            failures++;
            $display("FAIL run_start_len cycles=%0d required 10", start_cnt);
        end
    endtask

    task automatic test_run_strobe_ignored();
        int w0;
        bus.cmd = 2'b10;
        strobe_pulse(2);
        w0 = we_cnt;
        bus.cmd = 2'b01;
        strobe_pulse(2);
        bus.cmd = 2'b11;
        strobe_pulse(2);
        checks++;
        if (bus.state_o !== 3'd2 || bus.cpu_start !== 1'b1 || we_cnt !== w0) begin
            failures++;
            $display("FAIL run_strobe state=%0d start=%b writes=%0d required 2/1/%0d",
                     bus.state_o, bus.cpu_start, we_cnt, w0);
        end
        bus.cpu_halt = 1'b1;
        repeat (2) @(negedge clk);
        bus.cpu_halt = 1'b0;
        checks++;
        if (bus.state_o !== 3'd3) begin
            failures++;
            $display("FAIL run_strobe_exit state=%0d required 3", bus.state_o);
        end
    endtask

    task automatic test_halt_at_entry();
        bus.cpu_halt = 1'b1;
        bus.cmd = 2'b10;
        start_cnt = 0;
        strobe_pulse(2);
        checks++;
        if (start_cnt !== 1 || bus.state_o !== 3'd3 || bus.cpu_start !== 1'b0) begin
            failures++;
            $display("FAIL halt_at_entry pulses=%0d state=%0d required 1/3",
                     start_cnt, bus.state_o);
        end
        bus.cpu_halt = 1'b0;
    endtask

    task automatic test_dump();
        int w0;
        w0 = we_cnt;
        bus.cmd = 2'b11;
        strobe_pulse(2);
        checks++;
        if (bus.state_o !== 3'd4 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL dump_entry state=%0d busy=%b required 4/1",
                     bus.state_o, bus.busy);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (bus.mem_addr !== AW'(i)) begin
                failures++;
                $display("FAIL dump_addr[%0d] addr=%0d required %0d",
                         i, bus.mem_addr, i);
            end
            strobe_pulse(2);
        end
        checks++;
        if (bus.state_o !== 3'd3 || bus.mem_addr !== '0 || we_cnt !== w0) begin
            failures++;
            $display("FAIL dump_done state=%0d addr=%0d writes=%0d required 3/0/%0d",
                     bus.state_o, bus.mem_addr, we_cnt, w0);
        end
    endtask

    task automatic test_long_strobe();
        bus.cmd = 2'b11;
        strobe_pulse(2);
        strobe_pulse(20);
        checks++;
        if (bus.state_o !== 3'd4 || bus.mem_addr !== AW'(1)) begin
            failures++;
            $display("FAIL long_strobe state=%0d addr=%0d required 4/1",
                     bus.state_o, bus.mem_addr);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        checks++;
        if (bus.state_o !== 3'd0 || bus.mem_addr !== '0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid state=%0d addr=%0d busy=%b required 0/0/0",
                     bus.state_o, bus.mem_addr, bus.busy);
        end
    endtask

`ifdef RUN_TIMEOUT_EN
    task automatic test_timeout();
        int run_cycles;
        bit hit;
        bus.cpu_halt = 1'b0;
        bus.cmd = 2'b10;
        run_cycles = 0;
        hit = 0;
        @(negedge clk) bus.strobe = 1'b1;
        repeat (2) @(negedge clk);
        bus.strobe = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.state_o == 3'd2) run_cycles++;
            if (bus.state_o == 3'd5) begin
                hit = 1;
                break;
            end
        end
        checks++;
        if (!hit || run_cycles < 15 || run_cycles > 16 ||
            bus.cpu_start !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout hit=%0d run_cycles=%0d start=%b busy=%b required 1/15..16/0/0",
                     hit, run_cycles, bus.cpu_start, bus.busy);
        end
        bus.cmd = 2'b11;
        strobe_pulse(2);
        checks++;
        if (bus.state_o !== 3'd5) begin
            failures++;
            $display("FAIL error_hold state=%0d required 5", bus.state_o);
        end
        bus.cmd = 2'b01;
        strobe_pulse(2);
        checks++;
        if (bus.state_o !== 3'd1) begin
            failures++;
            $display("FAIL error_exit state=%0d required 1", bus.state_o);
        end
        apply_reset();
    endtask
`endif

    task automatic test_invariants();
        checks++;
        if (viol !== 0) begin
            failures++;
            $display("FAIL invariants violations=%0d required 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_nop();
        test_load();
        test_run();
        test_run_strobe_ignored();
        test_halt_at_entry();
        test_dump();
        test_long_strobe();
        test_reset_mid();
`ifdef RUN_TIMEOUT_EN
        test_timeout();
`endif
        test_nop();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
